javk_mem: RTL and testbench

Byte-wide RAM responder for the JAVK CPU bus: the target end of the `addrbus`/`databus`/`rw` interface that the CPU core initiates. It decodes a configurable address window, returns read data on `databus`, and commits CPU writes. It also contains a host program loader, driven by a valid/ready handshake, that fills the array from address 0 while the CPU is held in reset.

---
 rtl/javk_mem_pkg.sv | 13 +
 rtl/javk_mem_array.sv | 27 ++
 rtl/javk_mem.sv | 114 +++++++++++
 tb/tb_javk_mem.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/javk_mem_pkg.sv
// Shared definitions for the JAVK bus RAM responder: loader states and default geometry.
package javk_mem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } mem_state_e;

  localparam int unsigned DefDepthLog2 = 12;
  localparam logic [15:0] DefBase      = 16'h0000;

endpackage

// File: rtl/javk_mem_array.sv
// Byte storage: one asynchronous read port, one falling-edge write port. Contents are never reset.
module javk_mem_array
  import javk_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DefDepthLog2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [7:0]            wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [7:0]            rdata_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [7:0] mem_q [Depth];

  always_ff @(negedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/javk_mem.sv
// JAVK CPU bus RAM target with window decode, tri-state read path and a host program loader.
module javk_mem
  import javk_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DefDepthLog2,
  parameter logic [15:0] BASE       = DefBase
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         addrbus,
  input  logic                rw,
  inout  wire  [7:0]          databus,
  input  logic                load_en,
  input  logic                load_valid,
  input  logic [7:0]          load_data,
  output logic                load_ready,
  output logic                load_done,
  output logic [DEPTH_LOG2:0] load_count
);

  mem_state_e            state_q;
  logic [DEPTH_LOG2-1:0] ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  ready_q;
  logic                  done_q;

  logic                  sel;
  logic [DEPTH_LOG2-1:0] offset;
  logic                  bus_rd;
  logic                  bus_wr;
  logic                  ld_xfer;
  logic                  arr_we;
  logic [DEPTH_LOG2-1:0] arr_waddr;
  logic [7:0]            arr_wdata;
  logic [7:0]            arr_rdata;

  assign sel    = (addrbus[15:DEPTH_LOG2] == BASE[15:DEPTH_LOG2]);
  assign offset = addrbus[DEPTH_LOG2-1:0];

  // The CPU only owns the array while the loader is idle.
  assign bus_rd  = sel && !rw && (state_q == StIdle) && !rst;
  assign bus_wr  = sel &&  rw && (state_q == StIdle) && !rst;
  // Dropping load_en beats a same-edge valid byte.
  assign ld_xfer = (state_q == StLoad) && load_en && load_valid && !rst;

  assign arr_we    = bus_wr || ld_xfer;
  assign arr_waddr = ld_xfer ? ptr_q : offset;
  assign arr_wdata = ld_xfer ? load_data : databus;

  assign databus = bus_rd ? arr_rdata : {8{1'bz}};

  javk_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (clk),
    .we_i   (arr_we),
    .waddr_i(arr_waddr),
    .wdata_i(arr_wdata),
    .raddr_i(offset),
    .rdata_o(arr_rdata)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (load_en) begin
            state_q <= StLoad;
            ptr_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
          end
        end
        StLoad: begin
          if (!load_en) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
          end else if (load_valid) begin
            ptr_q   <= ptr_q + 1'b1;
            count_q <= count_q + 1'b1;
            // Last byte: stop here so the pointer never starts a second pass.
            if (ptr_q == '1) begin
              state_q <= StDone;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          if (!load_en) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = ready_q;
  assign load_done  = done_q;
  assign load_count = count_q;

endmodule

// File: tb/tb_javk_mem.sv
// Directed bench for javk_mem: bus read/write, window decode, loader streaming, stalls and aborts.
module tb_javk_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en, load_valid;
  logic [7:0]  load_data;

  logic [15:0] s_addr, b_addr;
  logic        s_rw, b_rw;
  logic [7:0]  s_drv, b_drv;
  logic        s_drv_en, b_drv_en;

  // Pulled-up buses: an undriven bus reads 8'hFF.
  tri1 [7:0]   s_bus, b_bus, a_bus;

  logic        s_ready, s_done;
  logic [4:0]  s_count;
  logic        b_ready, b_done, a_ready, a_done;
  logic [12:0] b_count, a_count;

  int total = 0;
  int bad   = 0;

  assign s_bus = s_drv_en ? s_drv : 8'hzz;
  assign b_bus = b_drv_en ? b_drv : 8'hzz;
  assign a_bus = b_drv_en ? b_drv : 8'hzz;

  always #5 clk = ~clk;

  javk_mem #(.DEPTH_LOG2(4)) u_small (
    .clk(clk), .rst(rst), .addrbus(s_addr), .rw(s_rw), .databus(s_bus),
    .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .load_ready(s_ready), .load_done(s_done), .load_count(s_count)
  );

  javk_mem u_big (
    .clk(clk), .rst(rst), .addrbus(b_addr), .rw(b_rw), .databus(b_bus),
    .load_en(1'b0), .load_valid(1'b0), .load_data(8'h00),
    .load_ready(b_ready), .load_done(b_done), .load_count(b_count)
  );

  javk_mem #(.BASE(16'h8000)) u_alt (
    .clk(clk), .rst(rst), .addrbus(b_addr), .rw(b_rw), .databus(a_bus),
    .load_en(1'b0), .load_valid(1'b0), .load_data(8'h00),
    .load_ready(a_ready), .load_done(a_done), .load_count(a_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    b_addr   = addr;
    b_rw     = 1'b1;
    b_drv    = data;
    b_drv_en = 1'b1;
    tick();
    b_rw     = 1'b0;
    b_drv_en = 1'b0;
    #1;
  endtask

  task automatic small_read(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    s_addr = addr;
    #1;
    chk(tag, s_bus, exp);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    s_addr = 16'h0000; s_rw = 1'b0; s_drv = 8'h00; s_drv_en = 1'b0;
    b_addr = 16'h0010; b_rw = 1'b0; b_drv = 8'h00; b_drv_en = 1'b0;
    tick();
    tick();

    chk("rst_ready", s_ready, 0);
    chk("rst_done", s_done, 0);
    chk("rst_count", s_count, 0);
    chk("rst_bus_z", b_bus, 8'hFF);

    // Reset gates the read drive; contents survive reset.
    rst = 1'b0;
    bus_write(16'h0010, 8'h5A);
    b_addr = 16'h0010; #1;
    chk("rd_0010", b_bus, 8'h5A);
    rst = 1'b1; #1;
    chk("rst_gates_rd", b_bus, 8'hFF);
    tick();
    rst = 1'b0; #1;
    chk("rd_after_rst", b_bus, 8'h5A);

    // Window decode: u_big at 0x0000, u_alt at 0x8000, 4 KiB each.
    bus_write(16'h8123, 8'h55);
    bus_write(16'h0123, 8'h3C);
    b_addr = 16'h0123; #1;
    chk("big_rd_0123", b_bus, 8'h3C);
    chk("alt_out_z", a_bus, 8'hFF);
    b_addr = 16'h8123; #1;
    chk("alt_rd_8123", a_bus, 8'h55);
    chk("big_out_z", b_bus, 8'hFF);
    b_addr = 16'h0010; b_rw = 1'b1; #1;
    chk("no_drive_rw", b_bus, 8'hFF);
    b_rw = 1'b0; #1;
    chk("big_idle_ready", {b_ready, b_done, a_ready, a_done}, 0);
    chk("big_idle_count", b_count | a_count, 0);

    // Full load of the 16-byte instance.
    load_en = 1'b1;
    tick();
    chk("ld_ready", s_ready, 1);
    chk("ld_count0", s_count, 0);
    small_read("rd_in_load_z", 16'h0000, 8'hFF);
    load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_data = 8'(8'hA0 + i);
      tick();
      if (i == 14) begin
        chk("ld_done_early", s_done, 0);
        chk("ld_count15", s_count, 15);
      end
    end
    chk("ld_done", s_done, 1);
    chk("ld_ready_off", s_ready, 0);
    chk("ld_count16", s_count, 16);
    load_valid = 1'b0;
    load_en = 1'b0;
    tick();
    chk("ld_done_clr", s_done, 0);
    small_read("ld_rd5", 16'h0005, 8'hA5);
    small_read("ld_rdF", 16'h000F, 8'hAF);

    // Stalled load with a CPU write attempt, aborted by dropping load_en.
    load_en = 1'b1;
    tick();
    for (int n = 0; n < 5; n++) begin
      load_valid = 1'b1;
      load_data  = 8'(8'hB0 + n);
      if (n == 2) begin
        s_addr = 16'h0002; s_rw = 1'b1; s_drv = 8'hEE; s_drv_en = 1'b1;
      end
      tick();
      s_rw = 1'b0; s_drv_en = 1'b0;
      load_valid = 1'b0;
      tick();
      if (n == 0) chk("stall_count1", s_count, 1);
    end
    chk("stall_ready", s_ready, 1);
    load_valid = 1'b1;
    load_data  = 8'hB5;
    load_en    = 1'b0;
    tick();
    load_valid = 1'b0;
    chk("abort_ready", s_ready, 0);
    chk("abort_count", s_count, 5);
    chk("abort_done", s_done, 0);
    small_read("abort_rd5", 16'h0005, 8'hA5);
    small_read("bus_ignored_rd2", 16'h0002, 8'hB2);
    small_read("stall_rd4", 16'h0004, 8'hB4);

    // Reset after three bytes; the byte offered on the reset edge is dropped.
    load_en = 1'b1;
    tick();
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_data = 8'(8'hC0 + i);
      tick();
    end
    load_data = 8'hC3;
    rst = 1'b1;
    tick();
    chk("rstld_ready", s_ready, 0);
    chk("rstld_count", s_count, 0);
    rst = 1'b0; load_en = 1'b0; load_valid = 1'b0;
    tick();
    chk("rstld_count_idle", s_count, 0);
    small_read("rstld_rd0", 16'h0000, 8'hC0);
    small_read("rstld_rd1", 16'h0001, 8'hC1);
    small_read("rstld_rd2", 16'h0002, 8'hC2);
    small_read("rstld_rd3", 16'h0003, 8'hB3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
